// File: rtl/rgb_pkg.sv
// Shared types and constants for the RGB LED arbiter and its PWM stage.
// Duty fields are DUTY_W wide; instances use the low PWM_BITS (PWM_BITS <= DUTY_W).
package rgb_pkg;

  localparam int unsigned CLK_HZ = 12_000_000;
  localparam int unsigned DUTY_W = 8;

  typedef struct packed {
    logic [DUTY_W-1:0] r;
    logic [DUTY_W-1:0] g;
    logic [DUTY_W-1:0] b;
  } rgb_duty_t;

  typedef enum logic {
    IDLE,
    HOLD
  } arb_state_t;

  localparam rgb_duty_t RED     = '{r: 8'hFF, g: 8'h00, b: 8'h00};
  localparam rgb_duty_t YELLOW  = '{r: 8'hFF, g: 8'hFF, b: 8'h00};
  localparam rgb_duty_t GREEN   = '{r: 8'h00, g: 8'hFF, b: 8'h00};
  localparam rgb_duty_t CYAN    = '{r: 8'h00, g: 8'hFF, b: 8'hFF};
  localparam rgb_duty_t BLUE    = '{r: 8'h00, g: 8'h00, b: 8'hFF};
  localparam rgb_duty_t MAGENTA = '{r: 8'hFF, g: 8'h00, b: 8'hFF};
  localparam rgb_duty_t OFF     = '{r: 8'h00, g: 8'h00, b: 8'h00};

endpackage

// File: rtl/rgb_led_arbiter_pwm.sv
// Three-channel PWM: free-running counter, each channel high while cnt < duty.
module rgb_pwm
  import rgb_pkg::*;
#(
  parameter int unsigned PWM_BITS = 8
) (
  input  logic      clk,
  input  logic      rst_n,
  input  rgb_duty_t duty,
  output logic      pwm_r,
  output logic      pwm_g,
  output logic      pwm_b
);

  logic [PWM_BITS-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      pwm_r <= 1'b0;
      pwm_g <= 1'b0;
      pwm_b <= 1'b0;
    end else begin
      cnt_q <= cnt_q + PWM_BITS'(1);
      pwm_r <= (cnt_q < duty.r[PWM_BITS-1:0]);
      pwm_g <= (cnt_q < duty.g[PWM_BITS-1:0]);
      pwm_b <= (cnt_q < duty.b[PWM_BITS-1:0]);
    end
  end

endmodule

// File: rtl/rgb_led_arbiter.sv
// Round-robin arbiter sharing one RGB LED between NUM_REQ requesters,
// with a minimum hold time per grant and a PWM output stage.
module rgb_led_arbiter
  import rgb_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 2000000,
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned PWM_BITS    = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*3*PWM_BITS-1:0] color,
  output logic [NUM_REQ-1:0]          grant,
  output logic                        busy,
  output logic                        RGB_R,
  output logic                        RGB_G,
  output logic                        RGB_B
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int unsigned CH_W  = 3 * PWM_BITS;

  arb_state_t         state_q, state_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0] grant_d;
  rgb_duty_t          duty_q, duty_d;

  logic               found;
  logic [IDX_W-1:0]   win;
  logic [IDX_W-1:0]   scan_idx;
  logic [CH_W-1:0]    sel_color;

  // Round-robin scan from last+1; the current holder is only eligible from IDLE.
  always_comb begin
    found    = 1'b0;
    win      = last_q;
    scan_idx = last_q;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      scan_idx = IDX_W'((32'(last_q) + k) % NUM_REQ);
      if (!found && req[scan_idx] && (k < NUM_REQ || state_q == IDLE)) begin
        found = 1'b1;
        win   = scan_idx;
      end
    end
  end

  // Next-state, grant, hold counter and duty selection.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    grant_d   = grant;
    duty_d    = '0;
    sel_color = color[32'(last_q)*CH_W +: CH_W];

    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = HOLD;
          grant_d = NUM_REQ'(1) << win;
          last_d  = win;
          cnt_d   = '0;
        end
      end
      HOLD: begin
        duty_d.r = DUTY_W'(sel_color[2*PWM_BITS +: PWM_BITS]);
        duty_d.g = DUTY_W'(sel_color[PWM_BITS +: PWM_BITS]);
        duty_d.b = DUTY_W'(sel_color[0 +: PWM_BITS]);
        if (!req[last_q]) begin
          cnt_d = '0;
          if (found) begin
            grant_d = NUM_REQ'(1) << win;
            last_d  = win;
          end else begin
            grant_d = '0;
            state_d = IDLE;
          end
        end else if (cnt_q < CNT_W'(HOLD_CYCLES - 1)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d = '0;
          if (found) begin
            grant_d = NUM_REQ'(1) << win;
            last_d  = win;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= IDX_W'(NUM_REQ - 1);
      cnt_q   <= '0;
      grant   <= '0;
      busy    <= 1'b0;
      duty_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      grant   <= grant_d;
      busy    <= |grant_d;
      duty_q  <= duty_d;
    end
  end

  rgb_pwm #(
    .PWM_BITS(PWM_BITS)
  ) u_pwm (
    .clk  (clk),
    .rst_n(rst_n),
    .duty (duty_q),
    .pwm_r(RGB_R),
    .pwm_g(RGB_G),
    .pwm_b(RGB_B)
  );

endmodule

// File: tb/tb_rgb_led_arbiter.sv
// Scoreboard bench for rgb_led_arbiter: a cycle-level ownership model predicts
// grant/busy, a monitor compares after each edge; PWM checked by duty counts.
module tb_rgb_led_arbiter;

  localparam int HOLD = 16;
  localparam int NR   = 4;
  localparam int PB   = 4;

  typedef struct packed {
    logic [NR-1:0] grant;
    logic          busy;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NR-1:0]     req = '0;
  logic [NR*3*PB-1:0] color = '0;
  logic [NR-1:0]     grant;
  logic              busy;
  logic              RGB_R, RGB_G, RGB_B;

  int checks = 0;
  int failures = 0;
  exp_t sb_q[$];

  // Reference model: who owns the LED and for how many cycles it has shown.
  int owner = -1;
  int last  = NR - 1;
  int age   = 0;
  int cnt_r, cnt_g, cnt_b;

  rgb_led_arbiter #(
    .HOLD_CYCLES(HOLD),
    .NUM_REQ    (NR),
    .PWM_BITS   (PB)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .req  (req),
    .color(color),
    .grant(grant),
    .busy (busy),
    .RGB_R(RGB_R),
    .RGB_G(RGB_G),
    .RGB_B(RGB_B)
  );

  always #5 clk = ~clk;

  function automatic int rr_pick(input int from, input logic [NR-1:0] r, input bit incl_self);
    for (int k = 1; k <= NR; k++) begin
      int idx;
      idx = (from + k) % NR;
      if (k == NR && !incl_self) return -1;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_step(input logic [NR-1:0] r);
    int w;
    if (owner < 0) begin
      w = rr_pick(last, r, 1'b1);
      if (w >= 0) begin owner = w; last = w; age = 1; end
    end else if (!r[owner]) begin
      w = rr_pick(owner, r, 1'b0);
      if (w >= 0) begin owner = w; last = w; age = 1; end
      else owner = -1;
    end else if (age < HOLD) begin
      age++;
    end else begin
      w = rr_pick(owner, r, 1'b0);
      if (w >= 0) begin owner = w; last = w; end
      age = 1;
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.grant = (owner < 0) ? '0 : (NR'(1) << owner);
    e.busy  = (owner >= 0);
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  // One cycle of stimulus: sample PWM, apply req, predict the next edge.
  task automatic step(input logic [NR-1:0] r);
    @(negedge clk);
    cnt_r += int'(RGB_R);
    cnt_g += int'(RGB_G);
    cnt_b += int'(RGB_B);
    req = r;
    model_step(r);
    sb_q.push_back(model_out());
  endtask

  task automatic rst_pulse();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    req   = '0;
    #1;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_rgb", 32'({RGB_R, RGB_G, RGB_B}), 32'h0);
    owner = -1; last = NR - 1; age = 0;
    sb_q.delete();
    #3;
    rst_n = 1'b1;
  endtask

  task automatic clear_counts();
    cnt_r = 0; cnt_g = 0; cnt_b = 0;
  endtask

  // Monitor: compares registered grant/busy just after each active edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checks++;
        if (grant !== e.grant || busy !== e.busy) begin
          failures++;
          $display("FAIL sb_grant t=%0t: got grant=%b busy=%b, want grant=%b busy=%b",
                   $time, grant, busy, e.grant, e.busy);
        end
        checks++;
        if ($countones(grant) > 1) begin
          failures++;
          $display("FAIL onehot t=%0t: got grant=%b, want at most one bit", $time, grant);
        end
      end
    end
  end

  initial begin
    logic [NR-1:0] r;
    #2;
    chk("init_grant", 32'(grant), 32'h0);
    chk("init_busy", 32'(busy), 32'h0);
    chk("init_rgb", 32'({RGB_R, RGB_G, RGB_B}), 32'h0);
    #10 rst_n = 1'b1;

    // Single requester, full red.
    color[11:0] = 12'hF00;
    for (int i = 0; i < 8; i++) step(4'b0001);
    clear_counts();
    for (int i = 0; i < 32; i++) step(4'b0001);
    chk("t1_red_high", 32'(cnt_r), 32'd30);
    chk("t1_green_high", 32'(cnt_g), 32'd0);
    chk("t1_blue_high", 32'(cnt_b), 32'd0);

    // Duty extremes on the same live grant.
    color[11:0] = 12'h08F;
    for (int i = 0; i < 4; i++) step(4'b0001);
    clear_counts();
    for (int i = 0; i < 32; i++) step(4'b0001);
    chk("t5_red_high", 32'(cnt_r), 32'd0);
    chk("t5_green_high", 32'(cnt_g), 32'd16);
    chk("t5_blue_high", 32'(cnt_b), 32'd30);

    // Contention between req0 and req2.
    rst_pulse();
    for (int i = 0; i < 50; i++) step(4'b0101);

    // Early release of req0 while req2 waits.
    rst_pulse();
    for (int i = 0; i < 6; i++) step(4'b0101);
    for (int i = 0; i < 10; i++) step(4'b0100);

    // Sole holder past expiry.
    rst_pulse();
    color[23:12] = 12'hFFF;
    for (int i = 0; i < 40; i++) step(4'b0010);

    // Async reset mid-hold, then all requesting: pointer restart order.
    rst_pulse();
    for (int i = 0; i < 70; i++) step(4'b1111);

    // Randomized requests and colours.
    r = 4'b0101;
    for (int i = 0; i < 600; i++) begin
      for (int b = 0; b < NR; b++)
        if ($urandom_range(0, 7) == 0) r[b] = ~r[b];
      if ($urandom_range(0, 15) == 0) color = 48'({$urandom(), $urandom()});
      step(r);
    end

    @(posedge clk);
    #2;
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
